// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 block sequencer: load, timed rounds, H fold, digest handshake
// Moore controller; every output decodes from registered state and counters only.
module sha256_round_ctrl #(
  parameter int unsigned ROUND_CYCLES = 2,
  parameter int unsigned NUM_ROUNDS   = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       blk_valid_i,
  input  logic       blk_first_i,
  output logic       blk_ready_o,
  input  logic       abort_i,
  output logic       ld_w_o,
  output logic       ld_state_o,
  output logic       h_init_o,
  output logic       rnd_en_o,
  output logic       sched_en_o,
  output logic       w_ext_o,
  output logic [5:0] rnd_idx_o,
  output logic       add_h_o,
  output logic       dig_valid_o,
  input  logic       dig_ready_i,
  output logic       busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] PH_LAST  = 2'(ROUND_CYCLES - 1);
  localparam logic [5:0] IDX_LAST = 6'(NUM_ROUNDS - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [5:0] idx_q, idx_d;
  logic       first_q, first_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    first_d = first_q;
    case (state_q)
      S_IDLE: begin
        if (blk_valid_i) begin
          state_d = S_LOAD;
          first_d = blk_first_i;
        end
      end
      S_LOAD: begin
        state_d = S_ROUND;
        phase_d = 2'd0;
        idx_d   = 6'd0;
      end
      S_ROUND: begin
        // The last phase of a round is the commit cycle; the index advances only after it.
        if (phase_q == PH_LAST) begin
          phase_d = 2'd0;
          if (idx_q == IDX_LAST) begin
            state_d = S_FINAL;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      S_FINAL: state_d = S_DONE;
      S_DONE: begin
        if (dig_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 2'd0;
        idx_d   = 6'd0;
      end
    endcase
    // Abort overrides any transition once a block has been taken.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      phase_d = 2'd0;
      idx_d   = 6'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      idx_q   <= 6'd0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  assign blk_ready_o = (state_q == S_IDLE);
  assign ld_w_o      = (state_q == S_LOAD);
  assign ld_state_o  = (state_q == S_LOAD);
  assign h_init_o    = (state_q == S_LOAD) && first_q;
  assign rnd_en_o    = (state_q == S_ROUND) && (phase_q == PH_LAST);
  assign sched_en_o  = (state_q == S_ROUND) && (phase_q == PH_LAST);
  assign w_ext_o     = (state_q == S_ROUND) && (idx_q >= 6'd16);
  assign rnd_idx_o   = idx_q;
  assign add_h_o     = (state_q == S_FINAL);
  assign dig_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);

endmodule
